half_scale_ctrl: RTL



---
 rtl/kyber_pkg.sv | 31 +++
 rtl/div2_chain.sv | 31 +++
 rtl/half_scale_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, controller state encoding and the single halving step
// used by the 2^-k scaling datapath.
package kyber_pkg;

    localparam int unsigned N         = 256;
    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 12;
    localparam int unsigned Q         = 3329;
    localparam int unsigned HALF_Q_P1 = 1665;
    localparam int unsigned MAX_SHIFT = 7;
    localparam int unsigned SW        = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    // Valid bit and RAM address travelling alongside a coefficient in the pipeline.
    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
    } pipe_tag_t;

    // x/2 mod q: odd values borrow (q+1)/2 so the shifted result stays exact.
    function automatic logic [DW-1:0] half_mod_q(input logic [DW-1:0] x);
        return {1'b0, x[DW-1:1]} + (x[0] ? DW'(HALF_Q_P1) : DW'(0));
    endfunction

endpackage

// File: rtl/div2_chain.sv
// Combinational cascade of MAX_SHIFT halving stages; the shift count picks the tap,
// with shift counts above MAX_SHIFT resolved to the last stage.
module div2_chain
    import kyber_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [SW-1:0] k,
    output logic [DW-1:0] y_c
);

    localparam int unsigned NSEL = 1 << SW;

    logic [DW-1:0] stage [MAX_SHIFT+1];
    logic [DW-1:0] sel   [NSEL];

    assign stage[0] = x;

    for (genvar s = 0; s < MAX_SHIFT; s++) begin : g_stage
        assign stage[s+1] = half_mod_q(stage[s]);
    end

    // Every encodable shift count maps to a tap; out-of-range counts clamp.
    for (genvar j = 0; j < NSEL; j++) begin : g_sel
        localparam int unsigned JU  = j;
        localparam int unsigned TAP = (JU > MAX_SHIFT) ? MAX_SHIFT : JU;
        assign sel[j] = stage[TAP];
    end

    assign y_c = sel[k];

endmodule

// File: rtl/half_scale_ctrl.sv
// In-place 2^-k mod q scaling of one polynomial: streams the RAM through the
// halving chain and writes each coefficient back two cycles after its read.
module half_scale_ctrl
    import kyber_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] shift_cnt,
    output logic          busy,
    output logic          done,
    output logic          range_err,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata
);

    state_e        state;
    state_e        state_nxt;
    logic          start_ok_c;
    logic [SW-1:0] k_q;
    pipe_tag_t     rd_tag;
    logic [DW-1:0] scaled_c;

    assign start_ok_c = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN ends on the cycle the final write is on the bus with nothing behind it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (ram_raddr == AW'(N - 1)) state_nxt = DRAIN;
            DRAIN:   if (ram_we && !rd_tag.vld) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and read port are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_re    <= 1'b0;
            ram_raddr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            k_q       <= '0;
        end else begin
            ram_re <= (state_nxt == READ);
            busy   <= (state_nxt == READ) || (state_nxt == DRAIN);
            done   <= (state_nxt == DONE);
            if (start_ok_c) begin
                ram_raddr <= '0;
                k_q       <= shift_cnt;
            end else if ((state == READ) && (state_nxt == READ)) begin
                ram_raddr <= ram_raddr + AW'(1);
            end
        end
    end

    // Sticky for the pass; cleared only by an accepted start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (start_ok_c) begin
            range_err <= 1'b0;
        end else if (rd_tag.vld && (ram_rdata >= DW'(Q))) begin
            range_err <= 1'b1;
        end
    end

    div2_chain u_chain (
        .x   (ram_rdata),
        .k   (k_q),
        .y_c (scaled_c)
    );

    // Read-data stage tag, then registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tag    <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            rd_tag.vld  <= ram_re;
            rd_tag.addr <= ram_raddr;
            ram_we      <= rd_tag.vld;
            if (rd_tag.vld) begin
                ram_waddr <= rd_tag.addr;
                ram_wdata <= scaled_c;
            end
        end
    end

endmodule
